ex_mul_unit: RTL and testbench
==============================

# ex_mul_unit

Iterative RV32M multiplier in the EX stage, the producer of the `mul_finish` stall qualifier used by the EX/MEM and upstream pipeline registers. It accepts a multiply from ID/EX and holds `mul_finish` low while computing. It then presents a registered 32-bit result with `mul_finish` high for exactly one cycle, so the EX/MEM register captures it on the following edge. Non-multiply instructions pass with `mul_finish` high and zero added latency.

## Interface
Parameters:
- none; fixed 32-bit datapath, radix-2, 32 iterations.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mul_valid  in  1  the instruction in EX is an M-extension op (opcode OP, funct7=0000001).
- funct3  in  3  ID_EX funct3; 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- rs1_data  in  32  forwarded rs1 operand.
- rs2_data  in  32  forwarded rs2 operand.
- mul_finish  out  1  1 means the pipeline may advance; 0 means stall EX/MEM and all upstream registers.
- mul_result  out  32  product selected by funct3; valid while mul_finish=1 in state DONE.

## Operation
- States: IDLE, BUSY, DONE.
- A start occurs when state=IDLE, mul_valid=1 and funct3[2]=0.
  - In the start cycle, mul_finish=0 combinationally.
  - On the start edge, the unit latches operand magnitudes, the sign flag, and funct3[1:0]. It clears the 64-bit accumulator and the 5-bit counter, then moves to BUSY.
- funct3[2]=1 (DIV/REM) is not handled here. With mul_valid=1 in IDLE there is no start, mul_finish=1, and mul_result is unchanged.
- Operand signedness:
  - rs1 is signed for MUL, MULH and MULHSU.
  - rs2 is signed for MUL and MULH.
  - A signed negative operand is replaced by its two's complement magnitude. 0x80000000 gives magnitude 0x80000000 as unsigned.
  - neg = sign1 XOR sign2, where only signed operands contribute.
- BUSY performs one iteration per cycle:
  - If multiplier bit[cnt] is 1, the accumulator adds the zero-extended multiplicand shifted left by cnt, modulo 2^64.
  - cnt increments each cycle.
  - When cnt=31 the iteration completes and the state moves to DONE.
- DONE entry, registered on the same edge as the last iteration:
  - The final product p is the accumulator, negated (64-bit two's complement) if neg.
  - mul_result = p[31:0] for MUL, or p[63:32] for MULH, MULHSU and MULHU.
- DONE: mul_finish=1 for one cycle, then unconditionally IDLE on the next edge.
- mul_finish = 0 when state=BUSY, or when state=IDLE and mul_valid=1 and funct3[2]=0. Otherwise it is 1.
- Operand or funct3 changes during BUSY or DONE are ignored.
- mul_valid dropping during BUSY does not abort; the sequence still completes through DONE.
- mul_result holds its value until the next DONE entry.
- No early termination: a zero operand still takes the full latency.

## Timing
- Reset values: state=IDLE, cnt=0, accumulator=0, latched operands=0, mul_result=0. mul_finish follows the IDLE equation, so it is 1 when mul_valid=0.
- rst asserted mid-BUSY or mid-DONE: immediate return to IDLE, mul_result=0, and the partial product is discarded. After release, a still-present mul_valid restarts from scratch.
- Latency, with the multiply entering EX in cycle 0:
  - Cycle 0: IDLE, mul_finish=0.
  - Cycles 1–32: BUSY, mul_finish=0.
  - Cycle 33: DONE, mul_finish=1, result valid.
  - EX/MEM captures at the end of cycle 33.
- Totals: 34 cycles in EX, of which mul_finish is low for 33.
- Back-to-back multiplies: the next multiply is in EX in cycle 34 with state=IDLE, so it starts immediately with no bubble.
- Non-multiply instruction: mul_finish=1 in the same cycle; 1-cycle EX.
- mul_finish depends combinationally only on state, mul_valid and funct3[2]; there is no path from the operands.

## Test plan
- MUL 7×6: mul_valid=1, funct3=000 at cycle 0 → mul_finish low cycles 0–32, high at cycle 33 only, mul_result=0x0000002A.
- Signed high halves:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULH 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
  - MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
- Mixed and unsigned, rs1=rs2=0xFFFFFFFF:
  - MULHSU → 0xFFFFFFFF.
  - MULHU → 0xFFFFFFFE.
- Back-to-back: MUL 3×5 then MULHU 0x10000×0x10000 → results 0x0000000F at cycle 33 and 0x00000001 at cycle 67. No extra idle cycle; the cycle-34 operand change must not corrupt the first result.
- Non-start cases:
  - mul_valid=1, funct3=100 → mul_finish stays 1, mul_result unchanged.
  - mul_valid=0 → mul_finish=1.
- Reset mid-operation: assert rst at cycle 15 of a MUL 9×9 → mul_result=0 and state IDLE immediately. After release with mul_valid held, the full 34-cycle sequence reruns and yields 0x00000051.

Source files
------------

// File: rtl/ex_mul_unit_if.sv
// Handshake bundle between the ID/EX pipeline side and the EX-stage multiplier.
// Latency: none, pure wiring.
// Backpressure: mul_finish low tells the pipeline side to hold EX/MEM and upstream.
interface ex_mul_unit_if;
  logic        mul_valid;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        mul_finish;
  logic [31:0] mul_result;

  modport master (
    output mul_valid,
    output funct3,
    output rs1_data,
    output rs2_data,
    input  mul_finish,
    input  mul_result
  );

  modport slave (
    input  mul_valid,
    input  funct3,
    input  rs1_data,
    input  rs2_data,
    output mul_finish,
    output mul_result
  );
endinterface

// File: rtl/ex_mul_unit.sv
// Iterative radix-2 RV32M multiplier (MUL/MULH/MULHSU/MULHU) living in EX.
// Latency: 34 cycles in EX for a multiply (finish low for 33), 1 cycle for anything else.
// Backpressure: mul_finish stalls EX/MEM and upstream; it never depends on the operands.
module ex_mul_unit (
  input  logic         clk,
  input  logic         rst,
  ex_mul_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        neg;
  logic [1:0]  op;
  logic [63:0] acc;
  logic [4:0]  cnt;
  logic [31:0] result;

  logic        start;
  logic        sign1;
  logic        sign2;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [63:0] acc_next;
  logic [63:0] prod;

  // Only IDLE can launch; DIV/REM encodings (funct3[2]=1) are left to another unit.
  assign start          = (state == IDLE) && bus.mul_valid && !bus.funct3[2];
  assign bus.mul_finish = !((state == BUSY) || start);
  assign bus.mul_result = result;

  // Operand magnitudes and sign: rs1 signed unless MULHU, rs2 signed only for MUL/MULH.
  always_comb begin
    sign1 = 1'b0;
    sign2 = 1'b0;
    mag1  = bus.rs1_data;
    mag2  = bus.rs2_data;
    sign1 = (bus.funct3[1:0] != 2'b11) && bus.rs1_data[31];
    sign2 = !bus.funct3[1] && bus.rs2_data[31];
    if (sign1) mag1 = ~bus.rs1_data + 32'd1;
    if (sign2) mag2 = ~bus.rs2_data + 32'd1;
  end

  // One shift-add step per cycle, plus the sign-corrected final product for the last step.
  always_comb begin
    acc_next = acc;
    prod     = 64'd0;
    if (mplier[cnt]) acc_next = acc + ({32'd0, mcand} << cnt);
    prod = neg ? (~acc_next + 64'd1) : acc_next;
  end

  // Control FSM and datapath registers; reset discards any partial product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= 32'd0;
      mplier <= 32'd0;
      neg    <= 1'b0;
      op     <= 2'b00;
      acc    <= 64'd0;
      cnt    <= 5'd0;
      result <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= mag1;
            mplier <= mag2;
            neg    <= sign1 ^ sign2;
            op     <= bus.funct3[1:0];
            acc    <= 64'd0;
            cnt    <= 5'd0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          acc <= acc_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            result <= (op == 2'b00) ? prod[31:0] : prod[63:32];
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mul_unit.sv
// Self-checking bench for ex_mul_unit: scoreboarded results, per-cycle stall checks.
// Inputs change on the falling edge; outputs are sampled on the falling edge (or #1 after).
// Every wait is a fixed cycle loop, so the run always reaches its summary.
module tb_ex_mul_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;

  ex_mul_unit_if bus();

  ex_mul_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res    = 32'd0;

  // Independent reference: sign-extend per funct3 and take a full 64-bit product.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax;
    logic [63:0] bx;
    logic [63:0] p;
    ax = (f[1:0] != 2'b11 && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
    bx = (!f[1] && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
    p  = ax * bx;
    return (f[1:0] == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    bus.mul_valid = 1'b1;
    bus.funct3    = f;
    bus.rs1_data  = a;
    bus.rs2_data  = b;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    bus.mul_valid = 1'b0;
    bus.funct3    = 3'b000;
    bus.rs1_data  = 32'd0;
    bus.rs2_data  = 32'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.mul_finish !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_finish: got %b want 1", bus.mul_finish);
    end
    vectors++;
    if (bus.mul_result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_result: got %h want 00000000", bus.mul_result);
    end
    rst = 1'b0;
  endtask

  task automatic test_mul_basic();
    logic [31:0] e;
    @(negedge clk);
    issue(3'b000, 32'd7, 32'd6, 32'h0000_002A);
    #1;
    vectors++;
    if (bus.mul_finish !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_c0_finish: got %b want 0", bus.mul_finish);
    end
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      vectors++;
      if (bus.mul_finish !== (k == 33)) begin
        miscompares++;
        $display("FAIL basic_finish cycle %0d: got %b want %b", k, bus.mul_finish, (k == 33));
      end
      if (k == 33) begin
        e = exp_q.pop_front();
        vectors++;
        if (bus.mul_result !== e) begin
          miscompares++;
          $display("FAIL basic_result: got %h want %h", bus.mul_result, e);
        end
        last_res = e;
      end
    end
    bus.mul_valid = 1'b0;
  endtask

  task automatic test_signed();
    logic [2:0]  tf[5] = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b011};
    logic [31:0] ta[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] tb[5] = '{32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] te[5] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [31:0] e;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      issue(tf[i], ta[i], tb[i], te[i]);
      for (int k = 1; k <= 33; k++) begin
        @(negedge clk);
        vectors++;
        if (bus.mul_finish !== (k == 33)) begin
          miscompares++;
          $display("FAIL signed%0d_finish cycle %0d: got %b want %b", i, k, bus.mul_finish, (k == 33));
        end
        if (k == 33) begin
          e = exp_q.pop_front();
          vectors++;
          if (bus.mul_result !== e) begin
            miscompares++;
            $display("FAIL signed%0d_result: got %h want %h", i, bus.mul_result, e);
          end
          last_res = e;
        end
      end
      bus.mul_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    @(negedge clk);
    issue(3'b000, 32'd3, 32'd5, 32'h0000_000F);
    for (int op_i = 0; op_i < 2; op_i++) begin
      #1;
      vectors++;
      if (bus.mul_finish !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b%0d_c0_finish: got %b want 0", op_i, bus.mul_finish);
      end
      for (int k = 1; k <= 33; k++) begin
        @(negedge clk);
        if (k == 10) begin
          bus.funct3   = 3'b011;
          bus.rs1_data = $urandom;
          bus.rs2_data = $urandom;
        end
        vectors++;
        if (bus.mul_finish !== (k == 33)) begin
          miscompares++;
          $display("FAIL b2b%0d_finish cycle %0d: got %b want %b", op_i, k, bus.mul_finish, (k == 33));
        end
        if (k == 33) begin
          e = exp_q.pop_front();
          vectors++;
          if (bus.mul_result !== e) begin
            miscompares++;
            $display("FAIL b2b%0d_result: got %h want %h", op_i, bus.mul_result, e);
          end
          last_res = e;
        end
      end
      if (op_i == 0) begin
        @(negedge clk);
        vectors++;
        if (bus.mul_result !== last_res) begin
          miscompares++;
          $display("FAIL b2b_hold_c34: got %h want %h", bus.mul_result, last_res);
        end
        issue(3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
      end
    end
    bus.mul_valid = 1'b0;
  endtask

  task automatic test_non_start();
    for (int f = 4; f < 8; f++) begin
      @(negedge clk);
      bus.mul_valid = 1'b1;
      bus.funct3    = f[2:0];
      bus.rs1_data  = $urandom;
      bus.rs2_data  = $urandom;
      @(negedge clk);
      vectors++;
      if (bus.mul_finish !== 1'b1) begin
        miscompares++;
        $display("FAIL nonstart_f%0d_finish: got %b want 1", f, bus.mul_finish);
      end
      vectors++;
      if (bus.mul_result !== last_res) begin
        miscompares++;
        $display("FAIL nonstart_f%0d_result: got %h want %h", f, bus.mul_result, last_res);
      end
    end
    @(negedge clk);
    bus.mul_valid = 1'b0;
    bus.funct3    = 3'b000;
    #1;
    vectors++;
    if (bus.mul_finish !== 1'b1) begin
      miscompares++;
      $display("FAIL novalid_finish: got %b want 1", bus.mul_finish);
    end
    @(negedge clk);
    vectors++;
    if (bus.mul_finish !== 1'b1 || bus.mul_result !== last_res) begin
      miscompares++;
      $display("FAIL novalid_idle: finish %b result %h want 1 %h", bus.mul_finish, bus.mul_result, last_res);
    end
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    for (int i = 0; i < 6; i++) begin
      f = 3'($urandom_range(0, 3));
      a = (i == 0) ? 32'd0 : $urandom;
      b = $urandom;
      @(negedge clk);
      issue(f, a, b, model(f, a, b));
      for (int k = 1; k <= 33; k++) begin
        @(negedge clk);
        if (k == 5) bus.mul_valid = 1'b0;
        vectors++;
        if (bus.mul_finish !== (k == 33)) begin
          miscompares++;
          $display("FAIL rand%0d_finish cycle %0d: got %b want %b", i, k, bus.mul_finish, (k == 33));
        end
        if (k == 33) begin
          e = exp_q.pop_front();
          vectors++;
          if (bus.mul_result !== e) begin
            miscompares++;
            $display("FAIL rand%0d_result f=%0d a=%h b=%h: got %h want %h", i, f, a, b, bus.mul_result, e);
          end
          last_res = e;
        end
      end
      bus.mul_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    @(negedge clk);
    bus.mul_valid = 1'b1;
    bus.funct3    = 3'b000;
    bus.rs1_data  = 32'd9;
    bus.rs2_data  = 32'd9;
    for (int k = 1; k <= 15; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.mul_result !== 32'h0) begin
      miscompares++;
      $display("FAIL rstmid_result: got %h want 00000000", bus.mul_result);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(32'h0000_0051);
    #1;
    vectors++;
    if (bus.mul_finish !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_c0_finish: got %b want 0", bus.mul_finish);
    end
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      vectors++;
      if (bus.mul_finish !== (k == 33)) begin
        miscompares++;
        $display("FAIL rstmid_finish cycle %0d: got %b want %b", k, bus.mul_finish, (k == 33));
      end
      if (k == 33) begin
        e = exp_q.pop_front();
        vectors++;
        if (bus.mul_result !== e) begin
          miscompares++;
          $display("FAIL rstmid_result_final: got %h want %h", bus.mul_result, e);
        end
        last_res = e;
      end
    end
    bus.mul_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_signed();
    test_back_to_back();
    test_non_start();
    test_random();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
